store_drain_buffer: RTL and testbench

- Receives the pending memory writes issued by the writeback stage for sd/sw/sh/sb.
- Queues them in a small FIFO and drains them one at a time to the memory-side write port using a req/ack handshake.
- Gives the load path a conservative address-conflict check, and gives the syscall path a flush-complete indication.

---
 rtl/store_pkg.sv | 32 +++
 rtl/store_fifo.sv | 73 +++++++
 rtl/store_drain_buffer.sv | 158 +++++++++++++++
 tb/tb_store_drain_buffer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types for the store drain buffer: size codes, queued-entry layout and data masking.
package store_pkg;

  localparam int SD_ADDR_W = 64;
  localparam int SD_REG_W  = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [SD_ADDR_W-1:0] addr;
    logic [SD_REG_W-1:0]  data;
    logic [1:0]           size;
  } store_entry_t;

  function automatic logic [SD_REG_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = SD_REG_W'(8'hFF);
      SZ_H:    size_mask = SD_REG_W'(16'hFFFF);
      SZ_W:    size_mask = SD_REG_W'(32'hFFFF_FFFF);
      default: size_mask = '1;
    endcase
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular store queue: storage, pointers, occupancy count, per-slot valid bits and
// doubleword tags so the parent can snoop every pending entry.
module store_fifo
  import store_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  store_entry_t         i_entry,
  input  logic                 i_pop,
  output store_entry_t         o_head,
  output store_entry_t         o_next,
  output logic [SD_ADDR_W-4:0] o_tags [DEPTH],
  output logic [DEPTH-1:0]     o_valid,
  output logic [PTR_WIDTH:0]   o_count,
  output logic                 o_full,
  output logic                 o_empty
);

  store_entry_t           r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]   r_wr_ptr;
  logic [PTR_WIDTH-1:0]   r_rd_ptr;
  logic [PTR_WIDTH:0]     r_count;
  logic [DEPTH-1:0]       r_valid;
  logic [DEPTH-1:0]       w_valid_nxt;
  logic [PTR_WIDTH-1:0]   w_rd_next;

  assign w_rd_next = r_rd_ptr + PTR_WIDTH'(1);

  always_comb begin
    w_valid_nxt = r_valid;
    if (i_pop)  w_valid_nxt[r_rd_ptr] = 1'b0;
    if (i_push) w_valid_nxt[r_wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      if (i_pop)  r_rd_ptr <= w_rd_next;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (PTR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
      r_valid <= w_valid_nxt;
    end
  end

  // Payload storage carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_entry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) o_tags[i] = r_mem[i].addr[SD_ADDR_W-1:3];
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_next  = r_mem[w_rd_next];
  assign o_valid = r_valid;
  assign o_count = r_count;
  assign o_full  = (r_count == (PTR_WIDTH+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/store_drain_buffer.sv
// Store drain buffer: queues writeback stores and drains them over a req/ack write port.
// STORE_DRAIN_PERFCNT_EN adds drained-store and stall-cycle counters (tied to 0 otherwise).
//
// state   | meaning
// ST_IDLE | no request on the bus
// ST_REQ  | head entry presented on out_bus_*, waiting for in_bus_ack
module store_drain_buffer
  import store_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = SD_ADDR_W,
  parameter int REGISTER_WIDTH = SD_REG_W,
  parameter int DEPTH          = 4,
  parameter int PTR_WIDTH      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_enable,
  input  logic [ADDRESS_WIDTH-1:0]  in_phy_addr,
  input  logic [REGISTER_WIDTH-1:0] in_data,
  input  logic [1:0]                in_size,
  output logic                      out_full,
  output logic                      out_empty,
  output logic                      out_overflow,
  output logic                      out_misaligned,
  input  logic [ADDRESS_WIDTH-1:0]  in_snoop_addr,
  output logic                      out_snoop_hit,
  input  logic                      in_flush,
  output logic                      out_flush_done,
  output logic                      out_bus_req,
  output logic [ADDRESS_WIDTH-1:0]  out_bus_addr,
  output logic [REGISTER_WIDTH-1:0] out_bus_data,
  output logic [1:0]                out_bus_size,
  input  logic                      in_bus_ack,
  output logic [31:0]               out_stores_drained,
  output logic [31:0]               out_stall_cycles
);

  drain_state_t          r_state, w_state_nxt;
  store_entry_t          r_bus;
  logic                  r_overflow, r_misaligned;
  store_entry_t          w_entry, w_head, w_next, w_bus_src;
  logic [SD_ADDR_W-4:0]  w_tags [DEPTH];
  logic [DEPTH-1:0]      w_valid;
  logic [PTR_WIDTH:0]    w_count;
  logic                  w_full, w_empty, w_misalign, w_push, w_pop, w_load, w_hit;
  logic                  w_unused_snoop_low;

  always_comb begin
    case (in_size)
      SZ_B:    w_misalign = 1'b0;
      SZ_H:    w_misalign = in_phy_addr[0];
      SZ_W:    w_misalign = |in_phy_addr[1:0];
      default: w_misalign = |in_phy_addr[2:0];
    endcase
  end

  assign w_push = in_enable & ~w_full & ~w_misalign;
  assign w_pop  = (r_state == ST_REQ) & in_bus_ack;

  assign w_entry.addr = SD_ADDR_W'(in_phy_addr);
  assign w_entry.data = SD_REG_W'(in_data) & size_mask(in_size);
  assign w_entry.size = in_size;

  store_fifo #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_tags  (w_tags),
    .o_valid (w_valid),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // After an ack the FSM reloads straight from the entry behind the head, giving one store per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_bus_src   = w_head;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_REQ;
          w_load      = 1'b1;
        end
      end
      default: begin
        if (in_bus_ack) begin
          if (w_count > (PTR_WIDTH+1)'(1)) begin
            w_load    = 1'b1;
            w_bus_src = w_next;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_bus        <= '0;
      r_overflow   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      if (w_load) r_bus <= w_bus_src;
      r_overflow   <= r_overflow | (in_enable & w_full);
      r_misaligned <= r_misaligned | (in_enable & w_misalign);
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_tags[i] == in_snoop_addr[ADDRESS_WIDTH-1:3])) w_hit = 1'b1;
    end
  end

  assign w_unused_snoop_low = ^in_snoop_addr[2:0];

`ifdef STORE_DRAIN_PERFCNT_EN
  logic [31:0] r_stores_drained, r_stall_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stores_drained <= '0;
      r_stall_cycles   <= '0;
    end else begin
      if (w_pop) r_stores_drained <= r_stores_drained + 32'd1;
      if ((r_state == ST_REQ) && !in_bus_ack) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign out_stores_drained = r_stores_drained;
  assign out_stall_cycles   = r_stall_cycles;
`else
  assign out_stores_drained = '0;
  assign out_stall_cycles   = '0;
`endif

  assign out_full       = w_full;
  assign out_empty      = w_empty;
  assign out_overflow   = r_overflow;
  assign out_misaligned = r_misaligned;
  assign out_snoop_hit  = w_hit;
  assign out_flush_done = in_flush & w_empty;
  assign out_bus_req    = (r_state == ST_REQ);
  assign out_bus_addr   = ADDRESS_WIDTH'(r_bus.addr);
  assign out_bus_data   = REGISTER_WIDTH'(r_bus.data);
  assign out_bus_size   = r_bus.size;

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: directed vector table, async-reset sequence, and
// randomized traffic checked against a queue-based reference model.
module tb_store_drain_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_enable;
  logic [63:0] in_phy_addr;
  logic [63:0] in_data;
  logic [1:0]  in_size;
  logic        out_full, out_empty, out_overflow, out_misaligned;
  logic [63:0] in_snoop_addr;
  logic        out_snoop_hit;
  logic        in_flush, out_flush_done;
  logic        out_bus_req;
  logic [63:0] out_bus_addr, out_bus_data;
  logic [1:0]  out_bus_size;
  logic        in_bus_ack;
  logic [31:0] out_stores_drained, out_stall_cycles;

  always #5 clk = ~clk;

  store_drain_buffer dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .in_phy_addr(in_phy_addr),
    .in_data(in_data), .in_size(in_size), .out_full(out_full), .out_empty(out_empty),
    .out_overflow(out_overflow), .out_misaligned(out_misaligned),
    .in_snoop_addr(in_snoop_addr), .out_snoop_hit(out_snoop_hit), .in_flush(in_flush),
    .out_flush_done(out_flush_done), .out_bus_req(out_bus_req), .out_bus_addr(out_bus_addr),
    .out_bus_data(out_bus_data), .out_bus_size(out_bus_size), .in_bus_ack(in_bus_ack),
    .out_stores_drained(out_stores_drained), .out_stall_cycles(out_stall_cycles)
  );

  typedef struct {
    logic        en;
    logic [63:0] addr, data;
    logic [1:0]  size;
    logic        ack;
    logic [63:0] snoop;
    logic        flush;
    logic        e_req;
    logic [63:0] e_addr, e_data;
    logic [1:0]  e_size;
    logic        e_full, e_empty, e_ovf, e_mis, e_hit, e_fdone;
  } vec_t;

  typedef struct {
    logic [63:0] addr, data;
    logic [1:0]  size;
  } ent_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  ent_t        mq[$];
  logic        m_req, m_ovf, m_mis;
  logic [31:0] m_drained, m_stall;
`ifdef STORE_DRAIN_PERFCNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic [63:0] addr, input logic [63:0] data,
                              input logic [1:0] size, input logic ack, input logic [63:0] snoop,
                              input logic flush, input logic e_req, input logic [63:0] e_addr,
                              input logic [63:0] e_data, input logic [1:0] e_size,
                              input logic e_full, input logic e_empty, input logic e_ovf,
                              input logic e_mis, input logic e_hit, input logic e_fdone);
    vec_t v;
    v.en = en; v.addr = addr; v.data = data; v.size = size; v.ack = ack; v.snoop = snoop;
    v.flush = flush; v.e_req = e_req; v.e_addr = e_addr; v.e_data = e_data; v.e_size = e_size;
    v.e_full = e_full; v.e_empty = e_empty; v.e_ovf = e_ovf; v.e_mis = e_mis;
    v.e_hit = e_hit; v.e_fdone = e_fdone;
    return v;
  endfunction

  function automatic logic [63:0] mask_of(input logic [1:0] size);
    if (size == 2'd3) return '1;
    return (64'd1 << (8 * (1 << size))) - 64'd1;
  endfunction

  function automatic bit model_hit(input logic [63:0] snoop);
    foreach (mq[i]) if ((mq[i].addr >> 3) == (snoop >> 3)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_req = 0; m_ovf = 0; m_mis = 0; m_drained = 0; m_stall = 0;
  endtask

  // Applies the current inputs to the model as of the coming rising edge.
  task automatic model_edge();
    int  cnt;
    bit  full, aligned, pop, push;
    ent_t e;
    cnt     = mq.size();
    full    = (cnt == 4);
    aligned = (in_phy_addr % (64'd1 << in_size)) == 0;
    pop     = m_req && in_bus_ack;
    push    = in_enable && !full && aligned;
    if (in_enable && full)     m_ovf = 1;
    if (in_enable && !aligned) m_mis = 1;
    if (pop) m_drained++;
    if (m_req && !in_bus_ack) m_stall++;
    m_req = m_req ? (in_bus_ack ? (cnt - 1 > 0) : 1'b1) : (cnt > 0);
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.addr = in_phy_addr; e.data = in_data & mask_of(in_size); e.size = in_size;
      mq.push_back(e);
    end
  endtask

  task automatic model_check(input string tag);
    n_vec++;
    chk({tag, "_full"}, out_full, mq.size() == 4);
    chk({tag, "_empty"}, out_empty, mq.size() == 0);
    chk({tag, "_req"}, out_bus_req, m_req);
    if (m_req) begin
      chk({tag, "_addr"}, out_bus_addr, mq[0].addr);
      chk({tag, "_data"}, out_bus_data, mq[0].data);
      chk({tag, "_size"}, out_bus_size, mq[0].size);
    end
    chk({tag, "_ovf"}, out_overflow, m_ovf);
    chk({tag, "_mis"}, out_misaligned, m_mis);
    chk({tag, "_hit"}, out_snoop_hit, model_hit(in_snoop_addr));
    chk({tag, "_fdone"}, out_flush_done, in_flush && mq.size() == 0);
    chk({tag, "_drained"}, out_stores_drained, PERF_ON ? m_drained : 32'd0);
    chk({tag, "_stall"}, out_stall_cycles, PERF_ON ? m_stall : 32'd0);
  endtask

  task automatic idle_inputs();
    in_enable = 0; in_phy_addr = 0; in_data = 0; in_size = 0;
    in_snoop_addr = 0; in_flush = 0; in_bus_ack = 0;
  endtask

  localparam logic [63:0] D1 = 64'h1122334455667788;
  localparam logic [63:0] DB = 64'hFFFF_FFFF_FFFF_FFAB;
  localparam logic [63:0] DS = 64'h0123456789ABCDEF;

  initial begin
    int guard;
    // en addr data size ack snoop flush | req baddr bdata bsize full empty ovf mis hit fdone
    tbl.push_back(mk(1, 64'h1000, D1, 3, 0, 64'h1000, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 64'h1000, 1,          0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 1, 64'h1000, D1, 3,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 1, 64'h1000, D1, 3,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 1, 64'h1000, D1, 3,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, 64'h1000, D1, 3,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,                 0, 0, 0, 0,  0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 64'h1003, DB, 0, 0, 0, 0,         0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, 64'h1003, 64'hAB, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 64'h1002, DS, 2, 0, 0, 0,         0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0,  0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0,  0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 64'h100, 64'd1, 3, 0, 0, 0,       0, 0, 0, 0,  0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 64'h108, 64'd2, 3, 0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 64'h110, 64'd3, 3, 0, 0, 0,       1, 64'h100, 64'd1, 3,  0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 64'h118, 64'd4, 3, 0, 0, 0,       1, 64'h100, 64'd1, 3,  0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 64'h120, 64'd5, 3, 1, 0, 0,       1, 64'h100, 64'd1, 3,  1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, 64'h108, 64'd2, 3,  0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, 64'h110, 64'd3, 3,  0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, 64'h118, 64'd4, 3,  0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0,  0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 64'h2008, DS, 3, 0, 64'h200C, 0,  0, 0, 0, 0,  0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 64'h200C, 1,          0, 0, 0, 0,  0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 64'h2010, 1,          1, 64'h2008, DS, 3,  0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 64'h200C, 1,          1, 64'h2008, DS, 3,  0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 64'h200C, 1,          0, 0, 0, 0,  0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0,  0, 1, 1, 1, 0, 0));

    idle_inputs();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    chk("rst_req", out_bus_req, 0);
    chk("rst_empty", out_empty, 1);
    chk("rst_full", out_full, 0);
    chk("rst_addr", out_bus_addr, 0);
    chk("rst_data", out_bus_data, 0);
    chk("rst_size", out_bus_size, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_mis", out_misaligned, 0);
    chk("rst_drained", out_stores_drained, 0);
    chk("rst_stall", out_stall_cycles, 0);
    reset = 1;

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      in_enable = tbl[i].en; in_phy_addr = tbl[i].addr; in_data = tbl[i].data;
      in_size = tbl[i].size; in_bus_ack = tbl[i].ack; in_snoop_addr = tbl[i].snoop;
      in_flush = tbl[i].flush;
      #2;
      n_vec++;
      chk({t, "_req"}, out_bus_req, tbl[i].e_req);
      if (tbl[i].e_req) begin
        chk({t, "_addr"}, out_bus_addr, tbl[i].e_addr);
        chk({t, "_data"}, out_bus_data, tbl[i].e_data);
        chk({t, "_size"}, out_bus_size, tbl[i].e_size);
      end
      chk({t, "_full"}, out_full, tbl[i].e_full);
      chk({t, "_empty"}, out_empty, tbl[i].e_empty);
      chk({t, "_ovf"}, out_overflow, tbl[i].e_ovf);
      chk({t, "_mis"}, out_misaligned, tbl[i].e_mis);
      chk({t, "_hit"}, out_snoop_hit, tbl[i].e_hit);
      chk({t, "_fdone"}, out_flush_done, tbl[i].e_fdone);
      @(posedge clk); #1;
    end

    // Reset asserted mid-cycle while a request is outstanding.
    idle_inputs();
    in_enable = 1; in_phy_addr = 64'h4000; in_data = DS; in_size = 3;
    @(posedge clk); #1;
    in_enable = 0;
    guard = 0;
    while (!out_bus_req && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    n_vec++;
    chk("arst_wait_req", out_bus_req, 1);
    #3;
    reset = 0;
    #1;
    n_vec++;
    chk("arst_req", out_bus_req, 0);
    chk("arst_empty", out_empty, 1);
    chk("arst_ovf", out_overflow, 0);
    chk("arst_mis", out_misaligned, 0);
    @(posedge clk); #1;
    reset = 1;
    model_reset();

    for (int c = 0; c < 800; c++) begin
      logic [1:0] sz;
      logic [63:0] off;
      sz = 2'($urandom_range(0, 3));
      off = 64'($urandom_range(0, 7)) & ~((64'd1 << sz) - 64'd1);
      if ($urandom_range(0, 15) == 0) off = 64'($urandom_range(1, 7));
      in_enable     = ($urandom_range(0, 2) != 0);
      in_size       = sz;
      in_phy_addr   = 64'h3000 + (64'($urandom_range(0, 15)) << 3) + off;
      in_data       = {$urandom, $urandom};
      in_bus_ack    = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_snoop_addr = 64'h3000 + 64'($urandom_range(0, 135));
      in_flush      = ($urandom_range(0, 3) == 0);
      #2;
      model_check($sformatf("rnd%0d", c));
      model_edge();
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
